uart_receiver: RTL and testbench

Serial-to-parallel UART receiver: the receive-side counterpart of the team's transmitter. It recovers one frame from the asynchronous `serial_in` line, checks parity and stop bit, and presents the data byte with a one-cycle valid strobe. The frame is 1 start bit, 8 data bits LSB-first, 1 parity bit and 1 stop bit. The block runs in the `sys_clk` domain and generates its own 16x oversampling tick.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/rx_tick_gen.sv | 34 +++
 rtl/uart_receiver.sv | 184 ++++++++++++++++++
 tb/tb_uart_receiver.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and baud divider helper.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BRK
  } rx_state_t;

  // Clocks per oversampling tick, never less than one.
  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned baud,
                                           input int unsigned oversample);
    int unsigned d;
    d = clk_freq / (baud * oversample);
    return (d == 0) ? 1 : d;
  endfunction

endpackage

// File: rtl/rx_tick_gen.sv
// Free-running oversampling tick divider, restartable so the first tick of a frame is aligned.
module rx_tick_gen #(
  parameter int unsigned DIV = 1
) (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CntLast = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: wrap at DIV-1 or jump back to zero on restart.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart || (cnt_q == CntLast)) begin
      cnt_d = '0;
    end
    tick = (cnt_q == CntLast);
  end

  // Divider counter register.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: 8 data bits LSB-first, parity, one stop bit, 16x-style oversampling.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD       = 115_200,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       rx_enable,
  input  logic       even_odd,
  input  logic       serial_in,
  output logic [7:0] rx_data_out,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int unsigned SCW = $clog2(OVERSAMPLE);
  localparam int unsigned BIW = $clog2(DATA_BITS);
  localparam logic [SCW-1:0] ScHalf = SCW'(OVERSAMPLE / 2 - 1);
  localparam logic [SCW-1:0] ScLast = SCW'(OVERSAMPLE - 1);
  localparam logic [BIW-1:0] BiLast = BIW'(DATA_BITS - 1);

  rx_state_t state_q, state_d;
  logic sync1_q, rx_s;
  logic [SCW-1:0] sc_q, sc_d;
  logic [BIW-1:0] bi_q, bi_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic pbit_q, pbit_d;
  logic eo_q, eo_d;
  logic [7:0] data_q, data_d;
  logic valid_q, valid_d;
  logic perr_q, perr_d;
  logic ferr_q, ferr_d;
  logic tick, restart;

  // Two-flop synchronizer; resets to the idle line level.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      sync1_q <= serial_in;
      rx_s    <= sync1_q;
    end
  end

  rx_tick_gen #(
    .DIV(DIV)
  ) u_tick_gen (
    .sys_clk(sys_clk),
    .rst_n  (rst_n),
    .restart(restart),
    .tick   (tick)
  );

  assign restart = (state_q == IDLE) && (state_d == START);

  // Next-state, sampling and result computation.
  always_comb begin
    state_d = state_q;
    sc_d    = sc_q;
    bi_d    = bi_q;
    shreg_d = shreg_q;
    pbit_d  = pbit_q;
    eo_d    = eo_q;
    data_d  = data_q;
    valid_d = 1'b0;
    perr_d  = 1'b0;
    ferr_d  = 1'b0;
    if (!rx_enable) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_d = START;
            sc_d    = '0;
            bi_d    = '0;
          end
        end
        START: begin
          if (tick) begin
            if (sc_q == ScHalf) begin
              if (rx_s) begin
                state_d = IDLE;  // glitch, not a real start bit
              end else begin
                eo_d    = even_odd;
                sc_d    = '0;
                state_d = DATA;
              end
            end else begin
              sc_d = sc_q + 1'b1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (sc_q == ScLast) begin
              sc_d          = '0;
              shreg_d[bi_q] = rx_s;
              if (bi_q == BiLast) begin
                state_d = PARITY;
              end else begin
                bi_d = bi_q + 1'b1;
              end
            end else begin
              sc_d = sc_q + 1'b1;
            end
          end
        end
        PARITY: begin
          if (tick) begin
            if (sc_q == ScLast) begin
              sc_d    = '0;
              pbit_d  = rx_s;
              state_d = STOP;
            end else begin
              sc_d = sc_q + 1'b1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (sc_q == ScLast) begin
              sc_d    = '0;
              valid_d = 1'b1;
              data_d  = shreg_q;
              perr_d  = ((^shreg_q) ^ pbit_q) != eo_q;
              ferr_d  = !rx_s;
              state_d = rx_s ? IDLE : BRK;
            end else begin
              sc_d = sc_q + 1'b1;
            end
          end
        end
        BRK: begin
          if (rx_s) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM, datapath and registered output state.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sc_q    <= '0;
      bi_q    <= '0;
      shreg_q <= '0;
      pbit_q  <= 1'b0;
      eo_q    <= 1'b0;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sc_q    <= sc_d;
      bi_q    <= bi_d;
      shreg_q <= shreg_d;
      pbit_q  <= pbit_d;
      eo_q    <= eo_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
    end
  end

  assign rx_data_out = data_q;
  assign rx_valid    = valid_q;
  assign parity_err  = perr_q;
  assign frame_err   = ferr_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver at 16 clocks per bit.
module tb_uart_receiver;

  localparam int BIT = 16;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  logic       sys_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_enable = 1'b0;
  logic       even_odd = 1'b0;
  logic       serial_in = 1'b1;
  logic [7:0] rx_data_out;
  logic       rx_valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int valid_cnt = 0;
  int busy_cnt = 0;
  int last_valid_cyc = 0;
  int prev_valid_cyc = 0;
  bit busy_seen = 1'b0;
  exp_t exp_q[$];

  uart_receiver #(
    .CLK_FREQ  (1_600_000),
    .BAUD      (100_000),
    .OVERSAMPLE(16)
  ) dut (
    .sys_clk    (sys_clk),
    .rst_n      (rst_n),
    .rx_enable  (rx_enable),
    .even_odd   (even_odd),
    .serial_in  (serial_in),
    .rx_data_out(rx_data_out),
    .rx_valid   (rx_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Output monitor: pops the scoreboard on every valid strobe.
  always @(negedge sys_clk) begin
    if (busy) begin
      busy_cnt++;
      busy_seen = 1'b1;
    end
    if (rx_valid) begin
      valid_cnt++;
      prev_valid_cyc = last_valid_cyc;
      last_valid_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("data", {24'd0, rx_data_out}, {24'd0, e.data});
        check("parity_err", {31'd0, parity_err}, {31'd0, e.perr});
        check("frame_err", {31'd0, frame_err}, {31'd0, e.ferr});
      end
    end else if (rst_n) begin
      check("flags_idle", {30'd0, parity_err, frame_err}, 32'd0);
    end
  end

  task automatic line_bit(input logic v, input int clocks);
    serial_in = v;
    repeat (clocks) @(negedge sys_clk);
  endtask

  // Drive a full frame and register what the receiver must report.
  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stopb);
    exp_t e;
    e.data = d;
    e.perr = ((^d) ^ pbit) != even_odd;
    e.ferr = !stopb;
    exp_q.push_back(e);
    line_bit(1'b0, BIT);
    for (int i = 0; i < 8; i++) line_bit(d[i], BIT);
    line_bit(pbit, BIT);
    line_bit(stopb, BIT);
  endtask

  // Start bit plus the first nbits data bits and half of the next one; no expectation.
  task automatic send_partial(input logic [7:0] d, input int nbits);
    line_bit(1'b0, BIT);
    for (int i = 0; i < nbits; i++) line_bit(d[i], BIT);
    line_bit(d[nbits], BIT / 2);
  endtask

  task automatic wait_valid(input string tag, input int target, input int budget);
    for (int i = 0; i < budget && valid_cnt < target; i++) @(negedge sys_clk);
    check(tag, valid_cnt, target);
  endtask

  initial begin
    int base;
    int gap;
    repeat (3) @(negedge sys_clk);
    check("rst_data", {24'd0, rx_data_out}, 32'd0);
    check("rst_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_flags", {30'd0, parity_err, frame_err}, 32'd0);
    rst_n = 1'b1;
    rx_enable = 1'b1;
    repeat (5) @(negedge sys_clk);

    // Clean frame, even parity; also measure busy length.
    even_odd = 1'b0;
    busy_cnt = 0;
    send_frame(8'hA5, 1'b0, 1'b1);
    line_bit(1'b1, 20);
    wait_valid("a5_valid", 1, 50);
    check("a5_busy_len_ok", {31'd0, (busy_cnt >= 162 && busy_cnt <= 168)}, 32'd1);

    // Wrong parity bit with odd parity selected.
    even_odd = 1'b1;
    send_frame(8'h01, 1'b1, 1'b1);
    line_bit(1'b1, 20);
    wait_valid("odd_valid", 2, 50);

    // Framing error followed by a long break.
    even_odd = 1'b0;
    send_frame(8'h3C, 1'b0, 1'b0);
    line_bit(1'b0, 40 * BIT);
    check("brk_one_valid", valid_cnt, 32'd3);
    check("brk_busy", {31'd0, busy}, 32'd1);
    line_bit(1'b1, 6);
    check("brk_exit", {31'd0, busy}, 32'd0);
    line_bit(1'b1, 20);

    // Short glitch on the idle line.
    busy_seen = 1'b0;
    line_bit(1'b0, 6);
    line_bit(1'b1, 40);
    check("glitch_busy_seen", {31'd0, busy_seen}, 32'd1);
    check("glitch_busy_end", {31'd0, busy}, 32'd0);
    check("glitch_no_valid", valid_cnt, 32'd3);

    // Back-to-back frames with no idle gap.
    send_frame(8'h55, 1'b0, 1'b1);
    send_frame(8'hAA, 1'b0, 1'b1);
    line_bit(1'b1, 20);
    wait_valid("b2b_valid", 5, 50);
    gap = last_valid_cyc - prev_valid_cyc;
    check("b2b_gap_ok", {31'd0, (gap >= 175 && gap <= 177)}, 32'd1);

    // Reset during data bit 4.
    base = valid_cnt;
    send_partial(8'hF0, 4);
    rst_n = 1'b0;
    #1;
    check("midrst_data", {24'd0, rx_data_out}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_valid", {31'd0, rx_valid}, 32'd0);
    line_bit(1'b1, 4);
    rst_n = 1'b1;
    line_bit(1'b1, 20);
    check("midrst_no_valid", valid_cnt, base);
    check("midrst_hold", {24'd0, rx_data_out}, 32'd0);
    send_frame(8'h5A, 1'b0, 1'b1);
    line_bit(1'b1, 20);
    wait_valid("after_rst_valid", base + 1, 50);

    // Enable drop mid-frame.
    base = valid_cnt;
    send_partial(8'h0F, 3);
    rx_enable = 1'b0;
    line_bit(1'b1, 3 * BIT);
    check("en_drop_busy", {31'd0, busy}, 32'd0);
    check("en_drop_no_valid", valid_cnt, base);
    check("en_drop_hold", {24'd0, rx_data_out}, 32'h5A);
    rx_enable = 1'b1;
    line_bit(1'b1, 10);
    even_odd = 1'b1;
    send_frame(8'hC3, 1'b1, 1'b1);
    line_bit(1'b1, 20);
    wait_valid("after_en_valid", base + 1, 50);

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
